// File: rtl/maxtree_batch_sched.sv
// maxtree_batch_sched: time-shares one 128-input pipelined max tree across
// NUM_BATCHES candidate banks. For each bank it selects the bank, pulses the
// tree start and waits out the tree latency. It then folds the tree result
// into a running maximum and returns the winner and its batch on a
// valid/ready port.
//
// Optional build macro MAXSCHED_PERF_EN adds a 16-bit perf_cycles output.
// perf_cycles holds the cycle count from request acceptance to the result
// handshake, and saturates at 0xFFFF.
module maxtree_batch_sched #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned INDX_WIDTH   = 10,
  parameter int unsigned ADDR_WIDTH   = 7,
  parameter int unsigned NUM_BATCHES  = 8,
  parameter int unsigned TREE_LATENCY = 7,
  localparam int unsigned W  = DATA_WIDTH + INDX_WIDTH + ADDR_WIDTH,
  localparam int unsigned BW = (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  output logic [BW-1:0] batch_sel,
  output logic          tree_start,
  input  logic [W-1:0]  tree_max,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [W-1:0]  res_data,
  output logic [BW-1:0] res_batch,
  output logic          busy
`ifdef MAXSCHED_PERF_EN
  ,
  output logic [15:0]   perf_cycles
`endif
);

  // Wait counter must hold TREE_LATENCY+1.
  localparam int unsigned CW = $clog2(TREE_LATENCY + 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_ACC    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [BW-1:0] LAST_B   = BW'(NUM_BATCHES - 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(TREE_LATENCY + 1);

  logic [2:0]      r_state;
  logic [2:0]      w_state_nxt;
  logic [BW-1:0]   r_b;
  logic [BW-1:0]   w_b_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_acc_load;
  logic            w_in_batch;

  logic [W-1:0]    r_acc;
  logic [BW-1:0]   r_acc_batch;

  logic            r_req_ready;
  logic            r_busy;
  logic            r_tree_start;
  logic [BW-1:0]   r_batch_sel;
  logic            r_res_valid;

  // Next-state, batch index, wait counter and accumulate-enable decode.
  always_comb begin
    w_state_nxt = r_state;
    w_b_nxt     = r_b;
    w_cnt_nxt   = r_cnt;
    w_acc_load  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid && r_req_ready) begin
          w_state_nxt = S_LAUNCH;
          w_b_nxt     = '0;
        end
      end
      S_LAUNCH: begin
        w_cnt_nxt   = CNT_LOAD;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt <= CW'(1)) begin
          w_state_nxt = S_ACC;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_ACC: begin
        // First batch always loads; later batches need a strictly larger
        // score, so ties keep the earlier batch.
        w_acc_load = (r_b == '0) ||
                     (tree_max[DATA_WIDTH-1:0] > r_acc[DATA_WIDTH-1:0]);
        if (r_b == LAST_B) begin
          w_state_nxt = S_DONE;
        end else begin
          w_b_nxt     = r_b + BW'(1);
          w_state_nxt = S_LAUNCH;
        end
      end
      S_DONE: begin
        if (r_res_valid && res_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Bank select is held for the whole LAUNCH/WAIT/ACC window of a batch.
  assign w_in_batch = (w_state_nxt == S_LAUNCH) ||
                      (w_state_nxt == S_WAIT)   ||
                      (w_state_nxt == S_ACC);

  // FSM state, batch index and wait counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_b     <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_b     <= w_b_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Registered control outputs, decoded from the upcoming state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_tree_start <= 1'b0;
      r_batch_sel  <= '0;
      r_res_valid  <= 1'b0;
    end else begin
      r_req_ready  <= (w_state_nxt == S_IDLE);
      r_busy       <= (w_state_nxt != S_IDLE);
      r_tree_start <= (w_state_nxt == S_LAUNCH);
      r_batch_sel  <= w_in_batch ? w_b_nxt : '0;
      r_res_valid  <= (w_state_nxt == S_DONE);
    end
  end

  // Running maximum over batches; it also serves as the result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_acc_batch <= '0;
    end else if (w_acc_load) begin
      r_acc       <= tree_max;
      r_acc_batch <= r_b;
    end
  end

  assign req_ready  = r_req_ready;
  assign busy       = r_busy;
  assign tree_start = r_tree_start;
  assign batch_sel  = r_batch_sel;
  assign res_valid  = r_res_valid;
  assign res_data   = r_acc;
  assign res_batch  = r_acc_batch;

`ifdef MAXSCHED_PERF_EN
  logic [15:0] r_perf_cnt;
  logic [15:0] r_perf_cycles;
  logic [15:0] w_perf_inc;
  logic        w_accept;
  logic        w_handshake;

  assign w_accept    = (r_state == S_IDLE) && (w_state_nxt == S_LAUNCH);
  assign w_handshake = (r_state == S_DONE) && (w_state_nxt == S_IDLE);
  assign w_perf_inc  = (r_perf_cnt == 16'hFFFF) ? r_perf_cnt : r_perf_cnt + 16'd1;

  // Operation cycle counter; the handshake cycle itself is included.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_cnt    <= 16'd0;
      r_perf_cycles <= 16'd0;
    end else begin
      if (w_accept) begin
        r_perf_cnt <= 16'd0;
      end else if (r_state != S_IDLE) begin
        r_perf_cnt <= w_perf_inc;
      end
      if (w_handshake) begin
        r_perf_cycles <= w_perf_inc;
      end
    end
  end

  assign perf_cycles = r_perf_cycles;
`endif

  // The start pulse may only appear while launching.
  a_start_in_launch: assert property (@(posedge clk) disable iff (!rst_n)
    r_tree_start |-> (r_state == S_LAUNCH));

  // The bank select must not move while the tree drains.
  a_sel_stable: assert property (@(posedge clk) disable iff (!rst_n)
    ((r_state == S_WAIT) || (r_state == S_ACC)) |-> (r_batch_sel == r_b));

endmodule

// File: tb/tb_maxtree_batch_sched.sv
// Bench for maxtree_batch_sched. It has a behavioural tree (pipeline of bank
// maxima), an operation-level reference model, per-cycle compares and
// literal checks. It also covers the MAXSCHED_PERF_EN build when that macro
// is defined.
module tb_maxtree_batch_sched;
  localparam int unsigned DW    = 16;
  localparam int unsigned IW    = 10;
  localparam int unsigned AW    = 7;
  localparam int unsigned NB    = 8;
  localparam int unsigned TL    = 7;
  localparam int unsigned W     = DW + IW + AW;
  localparam int unsigned BW    = 3;
  localparam int          P     = TL + 3;
  localparam int          OPLEN = NB * P;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [BW-1:0] batch_sel;
  logic          tree_start;
  logic [W-1:0]  tree_max;
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  res_data;
  logic [BW-1:0] res_batch;
  logic          busy;
`ifdef MAXSCHED_PERF_EN
  logic [15:0]   perf_cycles;
`endif

  maxtree_batch_sched #(
    .DATA_WIDTH(DW), .INDX_WIDTH(IW), .ADDR_WIDTH(AW),
    .NUM_BATCHES(NB), .TREE_LATENCY(TL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .batch_sel(batch_sel), .tree_start(tree_start), .tree_max(tree_max),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_batch(res_batch), .busy(busy)
`ifdef MAXSCHED_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_starts = 0;
  bit chk_en = 1'b0;

  logic [W-1:0] bank [NB][128];

  function automatic logic [W-1:0] mk(input int b, input int i, input int s);
    return {AW'(i), IW'(b * 128 + i), DW'(s)};
  endfunction

  function automatic logic [W-1:0] bank_max(input int b);
    logic [W-1:0] m;
    m = bank[b][0];
    for (int i = 1; i < 128; i++)
      if (bank[b][i][DW-1:0] > m[DW-1:0]) m = bank[b][i];
    return m;
  endfunction

  // Behavioural tree: re-samples the selected bank every edge, result TL edges later.
  logic [W-1:0] tpipe [TL+1];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i <= TL; i++) tpipe[i] <= '0;
    end else begin
      tpipe[0] <= bank_max(int'(batch_sel));
      for (int i = 1; i <= TL; i++) tpipe[i] <= tpipe[i-1];
    end
  end
  assign tree_max = tpipe[TL];

  // Operation-level reference model.
  bit           m_busy = 1'b0;
  int           m_k = 0;
  int           m_edge = 0;
  int           m_t0 = 0;
  logic [W-1:0] m_exp_data = '0;
  int           m_exp_batch = 0;
  int           m_perf = 0;
  always @(posedge clk) begin
    logic [W-1:0] w;
    m_edge++;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_k    = 0;
      m_perf = 0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy = 1'b1;
        m_k    = 0;
        m_t0   = m_edge;
        for (int b = 0; b < NB; b++) begin
          w = bank_max(b);
          if (b == 0 || w[DW-1:0] > m_exp_data[DW-1:0]) begin
            m_exp_data  = w;
            m_exp_batch = b;
          end
        end
      end
    end else if (m_k < OPLEN) begin
      m_k++;
    end else if (res_ready) begin
      m_busy = 1'b0;
      m_perf = (m_edge - m_t0 > 65535) ? 65535 : m_edge - m_t0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    bit e_rv, e_ts;
    int e_bs;
    e_rv = m_busy && (m_k >= OPLEN);
    e_ts = m_busy && (m_k < OPLEN) && (m_k % P == 0);
    e_bs = (m_busy && m_k < OPLEN) ? m_k / P : 0;
    chk("req_ready",  64'(req_ready),  64'(!m_busy));
    chk("busy",       64'(busy),       64'(m_busy));
    chk("res_valid",  64'(res_valid),  64'(e_rv));
    chk("tree_start", 64'(tree_start), 64'(e_ts));
    chk("batch_sel",  64'(batch_sel),  64'(e_bs));
    if (e_rv) begin
      chk("res_data",  64'(res_data),  64'(m_exp_data));
      chk("res_batch", 64'(res_batch), 64'(m_exp_batch));
    end
`ifdef MAXSCHED_PERF_EN
    chk("perf_model", 64'(perf_cycles), 64'(m_perf));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (tree_start === 1'b1) n_starts++;
    if (chk_en) compare_model();
  endtask

  task automatic fill_banks(input int mode);
    for (int b = 0; b < NB; b++)
      for (int i = 0; i < 128; i++)
        bank[b][i] = mk(b, i, (mode == 0) ? int'($urandom_range(0, 16'h1000)) : 16'h0123);
  endtask

  task automatic issue();
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_res(input int budget, output int n);
    n = 0;
    while (res_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    if (res_valid !== 1'b1) chk("res_valid_timeout", 64'(res_valid), 64'(1));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  64'(req_ready),  64'(1));
    chk({tag, "_busy"},       64'(busy),       64'(0));
    chk({tag, "_res_valid"},  64'(res_valid),  64'(0));
    chk({tag, "_tree_start"}, 64'(tree_start), 64'(0));
    chk({tag, "_batch_sel"},  64'(batch_sel),  64'(0));
    chk({tag, "_res_data"},   64'(res_data),   64'(0));
    chk({tag, "_res_batch"},  64'(res_batch),  64'(0));
`ifdef MAXSCHED_PERF_EN
    chk({tag, "_perf"},       64'(perf_cycles), 64'(0));
`endif
  endtask

  initial begin
    int n, s0;
    bit seen;
    rst_n = 1'b0; req_valid = 1'b0; res_ready = 1'b1;
    fill_banks(0);
    repeat (3) tick();
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (2) tick();

    // Unique maximum 0x7F00 in batch 5.
    fill_banks(0);
    bank[5][37] = mk(5, 37, 16'h7F00);
    s0 = n_starts;
    issue();
    wait_res(200, n);
    chk("t1_latency", 64'(n), 64'(80));
    chk("t1_starts",  64'(n_starts - s0), 64'(8));
    chk("t1_score",   64'(res_data[DW-1:0]), 64'(16'h7F00));
    chk("t1_data",    64'(res_data), 64'({7'd37, 10'd677, 16'h7F00}));
    chk("t1_batch",   64'(res_batch), 64'(5));
    tick();
    chk("t1_req_ready_after", 64'(req_ready), 64'(1));
    chk("t1_res_valid_after", 64'(res_valid), 64'(0));
`ifdef MAXSCHED_PERF_EN
    chk("t1_perf", 64'(perf_cycles), 64'(81));
`endif
    tick();

    // Tie between batch 2 and batch 6, with 20 cycles of backpressure.
    fill_banks(0);
    bank[2][10] = mk(2, 10, 16'h4000);
    bank[6][99] = mk(6, 99, 16'h4000);
    res_ready = 1'b0;
    issue();
    wait_res(200, n);
    chk("t2_latency", 64'(n), 64'(80));
    chk("t2_batch",   64'(res_batch), 64'(2));
    chk("t2_data",    64'(res_data), 64'({7'd10, 10'd266, 16'h4000}));
    repeat (20) tick();
    chk("t2_hold_valid", 64'(res_valid), 64'(1));
    chk("t2_hold_batch", 64'(res_batch), 64'(2));
    chk("t2_hold_data",  64'(res_data), 64'({7'd10, 10'd266, 16'h4000}));
    res_ready = 1'b1;
    tick();
    chk("t2_req_ready_after", 64'(req_ready), 64'(1));
    chk("t2_res_valid_after", 64'(res_valid), 64'(0));
`ifdef MAXSCHED_PERF_EN
    chk("t2_perf", 64'(perf_cycles), 64'(101));
`endif
    tick();

    // Request while busy at edge 20, reset at edge 35.
    fill_banks(0);
    bank[3][5] = mk(3, 5, 16'h7777);
    issue();
    repeat (19) tick();
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("t3_busy_mid", 64'(busy), 64'(1));
    chk("t3_req_ready_mid", 64'(req_ready), 64'(0));
    repeat (14) tick();
    rst_n = 1'b0;
    tick();
    chk_reset_outputs("t3_rst");
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (res_valid === 1'b1) seen = 1'b1;
    end
    chk("t3_no_result", 64'(seen), 64'(0));

    // Fresh operation after reset: 0x9000 in batch 7 beats 0x8FFF in batch 0.
    fill_banks(0);
    bank[0][0]   = mk(0, 0, 16'h8FFF);
    bank[7][127] = mk(7, 127, 16'h9000);
    issue();
    wait_res(200, n);
    chk("t4_latency", 64'(n), 64'(80));
    chk("t4_batch",   64'(res_batch), 64'(7));
    chk("t4_data",    64'(res_data), 64'({7'd127, 10'd1023, 16'h9000}));
    tick();
    tick();

    // All scores equal: batch 0 wins, first word of batch 0.
    fill_banks(1);
    issue();
    wait_res(200, n);
    chk("t5_latency", 64'(n), 64'(80));
    chk("t5_batch",   64'(res_batch), 64'(0));
    chk("t5_data",    64'(res_data), 64'({7'd0, 10'd0, 16'h0123}));
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
